// File: rtl/spike_net_interface_if.sv
// Spike/config/flit bundle between the neuron array, the node and the router.
// slave: the network interface; master: the neuron array and router side.
interface spike_net_interface_if #(
  parameter int NUM_NEURONS = 8,
  parameter int DATA_WIDTH  = 32
) ();
  logic [NUM_NEURONS-1:0] spike_vec;
  logic                   spike_valid;
  logic                   spike_ready;
  logic                   cfg_we;
  logic [7:0]             cfg_idx;
  logic [7:0]             cfg_dest;
  logic                   cfg_en;
  logic [DATA_WIDTH-1:0]  flit_out;
  logic                   flit_valid;
  logic                   flit_ready;
  logic                   busy;
  logic [7:0]             timestep;
  logic [15:0]            drop_count;

  modport slave (
    input  spike_vec, spike_valid,
    input  cfg_we, cfg_idx, cfg_dest, cfg_en,
    input  flit_ready,
    output spike_ready, flit_out, flit_valid,
    output busy, timestep, drop_count
  );

  modport master (
    output spike_vec, spike_valid,
    output cfg_we, cfg_idx, cfg_dest, cfg_en,
    output flit_ready,
    input  spike_ready, flit_out, flit_valid,
    input  busy, timestep, drop_count
  );
endinterface

// File: rtl/spike_net_interface.sv
// Injection NI: serialises a spike bitmap into routed flits via a FWFT FIFO.
// Ports: clk, rst (async high), nif (slave: spike in, cfg, flit out, status).
module spike_net_interface #(
  parameter int NUM_NEURONS = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NODE_X      = 0,
  parameter int NODE_Y      = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input logic clk,
  input logic rst,
  spike_net_interface_if.slave nif
);
  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e                 state_q;
  logic [NUM_NEURONS-1:0] pending_q;
  logic [7:0]             ts_q;
  logic [15:0]            drop_q;
  logic [7:0]             dest_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] en_q;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_q;
  logic [PW-1:0]          rd_q;
  logic [PW:0]            cnt_q;

  logic [IW-1:0]          k;
  logic [DATA_WIDTH-1:0]  flit_d;
  logic                   full, empty, hit, push, drop, pop, cfg_ok;

  // Lowest set bit of pending wins (scan downwards, last hit overrides).
  always_comb begin
    k = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--)
      if (pending_q[i]) k = IW'(i);
  end

  assign full   = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty  = (cnt_q == '0);
  assign hit    = (state_q == SCAN) && (|pending_q);
  assign push   = hit && en_q[k] && !full;
  assign drop   = hit && !en_q[k];
  assign pop    = !empty && nif.flit_ready;
  assign cfg_ok = nif.cfg_we && ({1'b0, nif.cfg_idx} < 9'(NUM_NEURONS));

  assign flit_d = {dest_q[k], 4'(NODE_X), 4'(NODE_Y), ts_q, 8'(k)};

  assign nif.spike_ready = (state_q == IDLE);
  assign nif.flit_valid  = !empty;
  assign nif.flit_out    = empty ? '0 : mem_q[rd_q];
  assign nif.busy        = (state_q == SCAN) || !empty;
  assign nif.timestep    = ts_q;
  assign nif.drop_count  = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ts_q      <= '0;
      drop_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (nif.spike_valid) begin
            pending_q <= nif.spike_vec;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (!(|pending_q)) begin
            state_q <= IDLE;
            ts_q    <= ts_q + 8'd1;
          end else if (push || drop) begin
            pending_q[k] <= 1'b0;
          end
          if (drop && (drop_q != 16'hFFFF))
            drop_q <= drop_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
    end else if (cfg_ok) begin
      en_q[nif.cfg_idx[IW-1:0]] <= nif.cfg_en;
    end
  end

  // Data storage needs no reset: valid bits and FIFO count gate its use.
  always_ff @(posedge clk) begin
    if (cfg_ok)
      dest_q[nif.cfg_idx[IW-1:0]] <= nif.cfg_dest;
    if (push)
      mem_q[wr_q] <= flit_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule
